// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - master-side and BRAM-side bus bundle of the memory arbiter
interface mem_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_BURST   = 8
);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam int IDX_W = $clog2(NUM_MASTERS);

    // GPU master side
    logic [NUM_MASTERS-1:0]                  i_m_req;
    logic [NUM_MASTERS-1:0]                  i_m_we;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  i_m_addr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  i_m_wdata;
    logic [NUM_MASTERS-1:0][LEN_W-1:0]       i_m_len;
    logic [NUM_MASTERS-1:0]                  o_m_gnt;
    logic [NUM_MASTERS-1:0]                  o_m_rvalid;
    logic [DATA_WIDTH-1:0]                   o_m_rdata;

    // BRAM side
    logic                                    o_s_req;
    logic                                    o_s_we;
    logic [ADDR_WIDTH-1:0]                   o_s_addr;
    logic [DATA_WIDTH-1:0]                   o_s_wdata;
    logic [DATA_WIDTH-1:0]                   i_s_rdata;

    // status
    logic                                    o_busy;
    logic [IDX_W-1:0]                        o_owner;

    // arbiter view
    modport slave (
        input  i_m_req, i_m_we, i_m_addr, i_m_wdata, i_m_len, i_s_rdata,
        output o_m_gnt, o_m_rvalid, o_m_rdata,
        output o_s_req, o_s_we, o_s_addr, o_s_wdata,
        output o_busy, o_owner
    );

    // environment view: the masters plus the BRAM
    modport master (
        output i_m_req, i_m_we, i_m_addr, i_m_wdata, i_m_len, i_s_rdata,
        input  o_m_gnt, o_m_rvalid, o_m_rdata,
        input  o_s_req, o_s_we, o_s_addr, o_s_wdata,
        input  o_busy, o_owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin burst-locking arbiter sharing one BRAM port among GPU masters
module mem_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_BURST   = 8
) (
    input  logic         clk,
    input  logic         glbl_rst_n,
    mem_arbiter_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam int IDX_W = $clog2(NUM_MASTERS);
    // one extra bit so rr_ptr + offset never wraps before the modulo fix-up
    localparam int CW    = IDX_W + 1;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
    localparam logic [CW-1:0]    NM      = CW'(NUM_MASTERS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]       rd_owner_q, rd_owner_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [CW-1:0]          cand;
    logic [LEN_W-1:0]       req_len;
    logic [LEN_W-1:0]       clamped_len;
    logic [CW-1:0]          next_ptr;

    logic                   own_req;
    logic                   own_we;
    logic [ADDR_WIDTH-1:0]  own_addr;
    logic [DATA_WIDTH-1:0]  own_wdata;
    logic                   beat;

    // Round-robin search: first requester found walking cyclically from rr_ptr
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= NM) begin
                cand = cand - NM;
            end
            if (!pick_found && bus.i_m_req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Clamp the winner's requested length into 1..MAX_BURST and compute the post-burst pointer
    always_comb begin
        req_len = bus.i_m_len[pick_idx];
        if (req_len == '0) begin
            clamped_len = LEN_W'(1);
        end else if (req_len > MAX_LEN) begin
            clamped_len = MAX_LEN;
        end else begin
            clamped_len = req_len;
        end
        next_ptr = {1'b0, owner_q} + CW'(1);
        if (next_ptr >= NM) begin
            next_ptr = '0;
        end
    end

    // Current owner's bus signals, used for beat detection and forwarding
    always_comb begin
        own_req   = bus.i_m_req[owner_q];
        own_we    = bus.i_m_we[owner_q];
        own_addr  = bus.i_m_addr[owner_q];
        own_wdata = bus.i_m_wdata[owner_q];
    end

    // Next-state logic: arbitrate in IDLE, count beats in BURST, release on last beat or dropped req
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        beat     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BURST;
                    owner_d = pick_idx;
                    len_d   = clamped_len;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (own_req) begin
                    beat  = 1'b1;
                    cnt_d = cnt_q + LEN_W'(1);
                end
                // an owner that stops requesting forfeits the rest of its burst
                if (!own_req || (cnt_q + LEN_W'(1) == len_q)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr[IDX_W-1:0];
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read-return tracking: remember who issued a read beat so its data is routed after gnt drops
    always_comb begin
        rd_pend_d  = beat && !own_we;
        rd_owner_d = beat ? owner_q : rd_owner_q;
        rdata_d    = rd_pend_q ? bus.i_s_rdata : rdata_q;
    end

    // State and pipeline registers; async reset drops any in-flight read return
    always_ff @(posedge clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs: grant from registered state, slave strobe only on beats, read data held between returns
    always_comb begin
        bus.o_m_gnt    = '0;
        bus.o_m_rvalid = '0;
        bus.o_s_req    = 1'b0;
        bus.o_s_we     = 1'b0;
        bus.o_s_addr   = '0;
        bus.o_s_wdata  = '0;
        bus.o_busy     = (state_q == ST_BURST);
        bus.o_owner    = owner_q;
        bus.o_m_rdata  = rd_pend_q ? bus.i_s_rdata : rdata_q;
        if (state_q == ST_BURST) begin
            bus.o_m_gnt[owner_q] = 1'b1;
        end
        if (rd_pend_q) begin
            bus.o_m_rvalid[rd_owner_q] = 1'b1;
        end
        if (beat) begin
            bus.o_s_req   = 1'b1;
            bus.o_s_we    = own_we;
            bus.o_s_addr  = own_addr;
            bus.o_s_wdata = own_wdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();

    mem_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .glbl_rst_n (rst_n),
        .bus        (bus)
    );

    // BRAM model with 1-cycle read latency and a preload port
    logic [31:0] bram [1024];
    logic [31:0] bram_q = '0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) begin
            bram[pl_addr] <= pl_data;
        end else if (bus.o_s_req) begin
            if (bus.o_s_we) bram[bus.o_s_addr[9:0]] <= bus.o_s_wdata;
            else            bram_q <= bram[bus.o_s_addr[9:0]];
        end
    end
    assign bus.i_s_rdata = bram_q;

    int n_vec = 0;
    int n_bad = 0;

    // master stimulus scripts
    int          launch_k [NM];
    int          stop_n   [NM];
    int          sent     [NM];
    logic [31:0] a0       [NM];
    logic [31:0] d0       [NM];
    logic [3:0]  l0       [NM];
    logic        w0       [NM];
    logic [NM-1:0] beat_prev;

    // per-cycle observation log
    logic [2:0]  g_log   [64];
    logic [2:0]  rv_log  [64];
    logic        sr_log  [64];
    logic        we_log  [64];
    logic        busy_log[64];
    logic [31:0] ad_log  [64];
    logic [31:0] wd_log  [64];
    logic [31:0] rd_log  [64];
    logic [1:0]  own_log [64];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_masters();
        bus.i_m_req   = '0;
        bus.i_m_we    = '0;
        bus.i_m_addr  = '0;
        bus.i_m_wdata = '0;
        bus.i_m_len   = '0;
        for (int i = 0; i < NM; i++) begin
            launch_k[i] = -1;
            stop_n[i]   = 0;
            sent[i]     = 0;
        end
    endtask

    task automatic cfg(input int i, input int lk, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] len, input int stop);
        launch_k[i] = lk;
        w0[i]       = we;
        a0[i]       = addr;
        d0[i]       = data;
        l0[i]       = len;
        stop_n[i]   = stop;
    endtask

    task automatic drive(input int k);
        for (int i = 0; i < NM; i++) begin
            if (beat_prev[i]) begin
                bus.i_m_addr[i]  = bus.i_m_addr[i] + 32'd1;
                bus.i_m_wdata[i] = bus.i_m_wdata[i] + 32'd1;
                sent[i]++;
                if (stop_n[i] != 0 && sent[i] == stop_n[i]) bus.i_m_req[i] = 1'b0;
            end
            if (k == launch_k[i]) begin
                bus.i_m_req[i]   = 1'b1;
                bus.i_m_we[i]    = w0[i];
                bus.i_m_addr[i]  = a0[i];
                bus.i_m_wdata[i] = d0[i];
                bus.i_m_len[i]   = l0[i];
                sent[i]          = 0;
            end
        end
    endtask

    task automatic run(input int n);
        beat_prev = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            drive(k);
            @(negedge clk);
            g_log[k]    = bus.o_m_gnt;
            rv_log[k]   = bus.o_m_rvalid;
            sr_log[k]   = bus.o_s_req;
            we_log[k]   = bus.o_s_we;
            ad_log[k]   = bus.o_s_addr;
            wd_log[k]   = bus.o_s_wdata;
            rd_log[k]   = bus.o_m_rdata;
            busy_log[k] = bus.o_busy;
            own_log[k]  = bus.o_owner;
            beat_prev   = bus.o_m_gnt & bus.i_m_req;
        end
    endtask

    task automatic do_reset();
        clear_masters();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic preload(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    function automatic int sreq_count(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) c += int'(sr_log[k]);
        return c;
    endfunction

    initial begin
        rst_n = 1'b0;
        clear_masters();
        beat_prev = '0;
        @(negedge clk);
        chk_eq("rst_gnt",    32'(bus.o_m_gnt), 32'h0);
        chk_eq("rst_rvalid", 32'(bus.o_m_rvalid), 32'h0);
        chk_eq("rst_rdata",  bus.o_m_rdata, 32'h0);
        chk_eq("rst_sreq",   32'(bus.o_s_req), 32'h0);
        chk_eq("rst_busy",   32'(bus.o_busy), 32'h0);
        chk_eq("rst_owner",  32'(bus.o_owner), 32'h0);
        for (int i = 0; i < 4; i++) preload(10'(16 + i), 32'hA0 + 32'(i));
        rst_n = 1'b1;

        // single master 0 read burst of 4
        clear_masters();
        cfg(0, 0, 1'b0, 32'h10, 32'h0, 4'd4, 4);
        run(7);
        chk_eq("t1_gnt_k0",   32'(g_log[0]), 32'h0);
        chk_eq("t1_gnt_k1",   32'(g_log[1]), 32'h1);
        chk_eq("t1_busy_k1",  32'(busy_log[1]), 32'h1);
        chk_eq("t1_addr_k1",  ad_log[1], 32'h10);
        chk_eq("t1_addr_k4",  ad_log[4], 32'h13);
        chk_eq("t1_beats",    32'(sreq_count(0, 6)), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk_eq($sformatf("t1_rvalid_%0d", j), 32'(rv_log[2 + j]), 32'h1);
            chk_eq($sformatf("t1_rdata_%0d", j),  rd_log[2 + j], 32'hA0 + 32'(j));
        end
        chk_eq("t1_gnt_k5",   32'(g_log[5]), 32'h0);
        chk_eq("t1_owner_k5", 32'(own_log[5]), 32'h0);
        chk_eq("t1_rvalid_k6", 32'(rv_log[6]), 32'h0);
        chk_eq("t1_rdata_hold", rd_log[6], 32'hA3);

        // all three masters continuously, len 2
        do_reset();
        for (int i = 0; i < NM; i++) cfg(i, 0, 1'b0, 32'h200 + 32'(i * 16), 32'h0, 4'd2, 0);
        run(17);
        begin
            logic [2:0] exp_g [17];
            exp_g = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100,
                      3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100};
            for (int k = 0; k < 17; k++) chk_eq($sformatf("t2_gnt_k%0d", k), 32'(g_log[k]), 32'(exp_g[k]));
        end
        chk_eq("t2_sreq_idle_k3", 32'(sr_log[3]), 32'h0);
        chk_eq("t2_owner_k4",     32'(own_log[4]), 32'h1);

        // master 2 writes 1,2,3 at 0x100, then master 0 reads them back
        do_reset();
        cfg(2, 0, 1'b1, 32'h100, 32'd1, 4'd3, 3);
        cfg(0, 4, 1'b0, 32'h100, 32'd0, 4'd3, 3);
        run(10);
        chk_eq("t3_gnt_k1",  32'(g_log[1]), 32'h4);
        chk_eq("t3_we_k1",   32'(we_log[1]), 32'h1);
        chk_eq("t3_wd_k2",   wd_log[2], 32'd2);
        chk_eq("t3_ad_k3",   ad_log[3], 32'h102);
        for (int k = 0; k < 6; k++) chk_eq($sformatf("t3_norv_k%0d", k), 32'(rv_log[k]), 32'h0);
        chk_eq("t3_gnt_k5",  32'(g_log[5]), 32'h1);
        for (int j = 0; j < 3; j++) begin
            chk_eq($sformatf("t3_rv_%0d", j), 32'(rv_log[6 + j]), 32'h1);
            chk_eq($sformatf("t3_rd_%0d", j), rd_log[6 + j], 32'(j + 1));
        end

        // master 1 len 8 drops after 3 beats; then 2 must win over 0
        do_reset();
        cfg(1, 0, 1'b0, 32'h20, 32'h0, 4'd8, 3);
        cfg(0, 1, 1'b0, 32'h30, 32'h0, 4'd1, 1);
        cfg(2, 1, 1'b0, 32'h40, 32'h0, 4'd1, 1);
        run(9);
        chk_eq("t4_beats",    32'(sreq_count(0, 5)), 32'd3);
        chk_eq("t4_gnt_k4",   32'(g_log[4]), 32'h2);
        chk_eq("t4_sreq_k4",  32'(sr_log[4]), 32'h0);
        chk_eq("t4_gnt_k5",   32'(g_log[5]), 32'h0);
        chk_eq("t4_busy_k5",  32'(busy_log[5]), 32'h0);
        chk_eq("t4_gnt_k6",   32'(g_log[6]), 32'h4);
        chk_eq("t4_gnt_k8",   32'(g_log[8]), 32'h1);

        // len 0 clamps to single-beat bursts
        do_reset();
        cfg(0, 0, 1'b0, 32'h50, 32'h0, 4'd0, 2);
        run(5);
        chk_eq("t5a_gnt_k1", 32'(g_log[1]), 32'h1);
        chk_eq("t5a_gnt_k2", 32'(g_log[2]), 32'h0);
        chk_eq("t5a_gnt_k3", 32'(g_log[3]), 32'h1);
        chk_eq("t5a_gnt_k4", 32'(g_log[4]), 32'h0);

        // len 15 clamps to 8 beats
        clear_masters();
        cfg(0, 0, 1'b0, 32'h60, 32'h0, 4'd15, 9);
        run(13);
        chk_eq("t5b_gnt_k8",  32'(g_log[8]), 32'h1);
        chk_eq("t5b_gnt_k9",  32'(g_log[9]), 32'h0);
        chk_eq("t5b_beats",   32'(sreq_count(0, 9)), 32'd8);
        chk_eq("t5b_gnt_k10", 32'(g_log[10]), 32'h1);

        // reset during beat 2 of a len 4 read; rr_ptr is 1 going in
        clear_masters();
        cfg(0, 0, 1'b0, 32'h10, 32'h0, 4'd4, 0);
        run(3);
        chk_eq("t6_rv_k2",   32'(rv_log[2]), 32'h1);
        chk_eq("t6_sreq_k2", 32'(sr_log[2]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_gnt",    32'(bus.o_m_gnt), 32'h0);
        chk_eq("t6_rst_sreq",   32'(bus.o_s_req), 32'h0);
        chk_eq("t6_rst_busy",   32'(bus.o_busy), 32'h0);
        chk_eq("t6_rst_rvalid", 32'(bus.o_m_rvalid), 32'h0);
        chk_eq("t6_rst_rdata",  bus.o_m_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("t6_rv_suppressed", 32'(bus.o_m_rvalid), 32'h0);
        clear_masters();
        rst_n = 1'b1;
        cfg(0, 0, 1'b0, 32'h10, 32'h0, 4'd1, 1);
        cfg(1, 0, 1'b0, 32'h11, 32'h0, 4'd1, 1);
        run(3);
        chk_eq("t6_first_gnt", 32'(g_log[1]), 32'h1);
        chk_eq("t6_owner",     32'(own_log[1]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
